data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, extra memory-access cycles per transfer (0..7).
REQ-002 SHALL have parameter BASE_ADDR, default 16'h0500, lowest data-memory byte address.
REQ-003 SHALL have parameter TOP_ADDR, default 16'h08FF, highest data-memory byte address.
REQ-004 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-005 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports req0/req1  input  1  transfer request, port 0 = CPU, port 1 = debug/DMA.
REQ-007 SHALL have ports we0/we1  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports addr0/addr1  input  16  byte address.
REQ-009 SHALL have ports wdata0/wdata1  input  32  write data.
REQ-010 SHALL have ports gnt0/gnt1  output  1  port owns the memory.
REQ-011 SHALL have ports ack0/ack1  output  1  one-cycle completion pulse.
REQ-012 SHALL have ports err0/err1  output  1  one-cycle out-of-range pulse.
REQ-013 SHALL have port rdata  output  32  read data, valid while ack0 or ack1 is high.
REQ-014 SHALL have port mem_cs_n  output  1  active-low memory chip select.
REQ-015 SHALL have port mem_we  output  1  memory write enable.
REQ-016 SHALL have port mem_addr  output  10  address offset (addr - BASE_ADDR)[9:0].
REQ-017 SHALL have ports mem_wdata  output  32  and mem_rdata  input  32.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, DONE, ERROR.
REQ-019 SHALL sample req0/req1 only in IDLE; requests in other states are held off, not lost, while req stays high.
REQ-020 SHALL arbitrate in IDLE round-robin: on a tie, the winner is the port not granted last; a lone request wins immediately.
REQ-021 SHALL, on a win, latch the winner's we, addr, and wdata, assert its gnt, and hold gnt through DONE or ERROR.
REQ-022 SHALL decode the full 16-bit address: in range iff BASE_ADDR <= addr <= TOP_ADDR, inclusive at both ends.
REQ-023 SHALL go IDLE->ACCESS when the address is in range, and IDLE->ERROR otherwise.
REQ-024 SHALL, in ACCESS, drive mem_cs_n=0 and mem_we=latched we, with mem_addr and mem_wdata stable, for exactly 1+WAIT_STATES cycles, then go to DONE.
REQ-025 SHALL capture mem_rdata into rdata on the final ACCESS cycle for reads.
REQ-026 SHALL, in DONE, pulse the winner's ack for one cycle and then go to IDLE.
REQ-027 SHALL, in ERROR, pulse the winner's err for one cycle with no memory cycle (mem_cs_n=1), then go to IDLE.
REQ-028 SHALL give a latency of 2+WAIT_STATES cycles from the IDLE sampling edge to ack, and 1 cycle to err.
REQ-029 SHALL require the requester to drop req in its ack/err cycle; a req still high in IDLE starts a new transfer.
REQ-030 SHALL keep mem_cs_n=1 and mem_we=0 in every state except ACCESS.
REQ-031 SHALL never assert gnt0 and gnt1 together, never assert ack and err together, and never give a port more than one outstanding transfer.
REQ-032 SHALL hold rdata from the last read until the next read completes; writes leave rdata unchanged.

Reset
REQ-033 SHALL, on RST=0, immediately drive FSM=IDLE, gnt*/ack*/err*=0, mem_cs_n=1, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, and last-grant=port 1 (so port 0 wins the first tie).
REQ-034 SHALL abort a transfer in progress when reset is asserted mid-transfer, with no ack or err issued.
REQ-035 SHALL sample requests again on the first rising edge after RST is released.

Verification
REQ-036 Single read: req0, we0=0, addr0=16'h0500, mem_rdata=32'hDEADBEEF, WAIT_STATES=1 -> mem_cs_n low 2 cycles with mem_addr=0, ack0 at cycle 3, rdata=32'hDEADBEEF.
REQ-037 Boundary: addr 16'h08FF -> memory cycle with mem_addr=10'h3FF; addr 16'h04FF and 16'h0900 -> err at cycle 1 with mem_cs_n held at 1.
REQ-038 Contention: req0 and req1 high together, held until served -> order is port 0, port 1, port 0, port 1, and gnt0/gnt1 never overlap.
REQ-039 Write: req1, we1=1, addr1=16'h0700, wdata1=32'h12345678 -> mem_we=1, mem_addr=10'h200, mem_wdata=32'h12345678, ack1 pulses, rdata unchanged.
REQ-040 Reset mid-ACCESS: RST=0 on the first ACCESS cycle -> mem_cs_n=1 at once, no ack; after release, a held req0 is served normally.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Out-of-range addresses are answered with an err pulse and never touch the memory.
module data_mem_arbiter #(
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [15:0] BASE_ADDR   = 16'h0500,
    parameter logic [15:0] TOP_ADDR    = 16'h08FF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata,
    output logic        mem_cs_n,
    output logic        mem_we,
    output logic [9:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    // state  | meaning
    // IDLE   | sampling requests, arbitrating
    // ACCESS | memory cycle in progress (1+WAIT_STATES cycles)
    // DONE   | ack pulse to the owner
    // ERROR  | err pulse to the owner, no memory cycle
    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERROR} state_t;

    state_t      state, state_nxt;
    logic        owner;
    logic        last_gnt;
    logic        lat_we;
    logic [2:0]  wait_cnt;

    logic        any_req;
    logic        win;
    logic [15:0] sel_addr;
    logic        in_range;
    logic [9:0]  offset;

    always_comb begin
        any_req  = req0 | req1;
        // On a tie the port not granted last wins; a lone request wins outright.
        win      = (req0 && req1) ? ~last_gnt : ~req0;
        sel_addr = win ? addr1 : addr0;
        in_range = (sel_addr >= BASE_ADDR) && (sel_addr <= TOP_ADDR);
        offset   = sel_addr[9:0] - BASE_ADDR[9:0];
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = in_range ? ACCESS : ERROR;
            ACCESS:  if (wait_cnt == 3'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            ERROR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            owner     <= 1'b0;
            last_gnt  <= 1'b1;
            lat_we    <= 1'b0;
            wait_cnt  <= 3'd0;
            mem_addr  <= 10'd0;
            mem_wdata <= 32'd0;
            rdata     <= 32'd0;
        end else if (state == IDLE && any_req) begin
            owner    <= win;
            last_gnt <= win;
            lat_we   <= win ? we1 : we0;
            wait_cnt <= 3'(WAIT_STATES);
            if (in_range) begin
                mem_addr  <= offset;
                mem_wdata <= win ? wdata1 : wdata0;
            end
        end else if (state == ACCESS) begin
            if (wait_cnt == 3'd0) begin
                if (!lat_we) rdata <= mem_rdata;
            end else begin
                wait_cnt <= wait_cnt - 3'd1;
            end
        end
    end

    assign mem_cs_n = (state != ACCESS);
    assign mem_we   = (state == ACCESS) && lat_we;
    assign gnt0     = (state != IDLE) && !owner;
    assign gnt1     = (state != IDLE) && owner;
    assign ack0     = (state == DONE) && !owner;
    assign ack1     = (state == DONE) && owner;
    assign err0     = (state == ERROR) && !owner;
    assign err1     = (state == ERROR) && owner;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with WAIT_STATES=1 and default address window.
module tb_data_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [15:0] addr0 = 0, addr1 = 0;
    logic [31:0] wdata0 = 0, wdata1 = 0;
    logic        gnt0, gnt1, ack0, ack1, err0, err1;
    logic [31:0] rdata;
    logic        mem_cs_n, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 0;

    int n_checks = 0;
    int n_fail   = 0;

    data_mem_arbiter #(.WAIT_STATES(1), .BASE_ADDR(16'h0500), .TOP_ADDR(16'h08FF)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata(rdata), .mem_cs_n(mem_cs_n), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        int order[4];
        int n_ack;
        int budget;

        // Reset state
        @(negedge CLK);
        check("rst_gnt", {gnt0, gnt1}, 0);
        check("rst_ack_err", {ack0, ack1, err0, err1}, 0);
        check("rst_cs_n", mem_cs_n, 1);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rdata", rdata, 0);
        RST = 1'b1;

        // Single read at BASE_ADDR
        req0 = 1; we0 = 0; addr0 = 16'h0500; mem_rdata = 32'hDEADBEEF;
        step();
        check("rd_c1_cs", mem_cs_n, 0);
        check("rd_c1_addr", mem_addr, 10'h000);
        check("rd_c1_gnt", {gnt0, gnt1}, 2'b10);
        check("rd_c1_we", mem_we, 0);
        check("rd_c1_ack", ack0, 0);
        step();
        check("rd_c2_cs", mem_cs_n, 0);
        check("rd_c2_ack", ack0, 0);
        step();
        check("rd_c3_ack", {ack0, ack1, err0, err1}, 4'b1000);
        check("rd_c3_cs", mem_cs_n, 1);
        check("rd_c3_rdata", rdata, 32'hDEADBEEF);
        check("rd_c3_gnt", gnt0, 1);
        req0 = 0;
        step();
        check("rd_idle_gnt", {gnt0, gnt1}, 0);
        check("rd_idle_ack", ack0, 0);
        check("rd_idle_rdata", rdata, 32'hDEADBEEF);

        // Top-of-range read
        req0 = 1; addr0 = 16'h08FF; mem_rdata = 32'hA5A5A5A5;
        step();
        check("top_cs", mem_cs_n, 0);
        check("top_addr", mem_addr, 10'h3FF);
        step();
        step();
        check("top_ack", ack0, 1);
        check("top_rdata", rdata, 32'hA5A5A5A5);
        req0 = 0;
        step();

        // Just below range on port 1
        req1 = 1; we1 = 0; addr1 = 16'h04FF;
        step();
        check("low_err", {ack0, ack1, err0, err1}, 4'b0001);
        check("low_cs", mem_cs_n, 1);
        check("low_gnt", {gnt0, gnt1}, 2'b01);
        req1 = 0;
        step();
        check("low_after", {err1, gnt1, mem_cs_n}, 3'b001);

        // Just above range on port 0
        req0 = 1; addr0 = 16'h0900;
        step();
        check("high_err", {ack0, ack1, err0, err1}, 4'b0010);
        check("high_cs", mem_cs_n, 1);
        req0 = 0;
        step();
        check("high_after", {err0, mem_cs_n}, 2'b01);

        // Write on port 1
        req1 = 1; we1 = 1; addr1 = 16'h0700; wdata1 = 32'h12345678; mem_rdata = 32'hFFFFFFFF;
        step();
        check("wr_we", mem_we, 1);
        check("wr_cs", mem_cs_n, 0);
        check("wr_addr", mem_addr, 10'h200);
        check("wr_wdata", mem_wdata, 32'h12345678);
        check("wr_gnt", {gnt0, gnt1}, 2'b01);
        step();
        check("wr_c2_we", mem_we, 1);
        step();
        check("wr_ack", {ack0, ack1, err0, err1}, 4'b0100);
        check("wr_we_off", mem_we, 0);
        check("wr_rdata", rdata, 32'hA5A5A5A5);
        req1 = 0; we1 = 0;
        step();

        // Contention: both held, expect 0,1,0,1
        req0 = 1; req1 = 1; addr0 = 16'h0500; addr1 = 16'h0504;
        n_ack = 0;
        budget = 0;
        while (n_ack < 4 && budget < 40) begin
            step();
            budget++;
            check("cont_gnt_overlap", {gnt0 & gnt1}, 0);
            if (ack0 || ack1) begin
                order[n_ack] = ack1 ? 1 : 0;
                n_ack++;
            end
        end
        check("cont_budget", n_ack, 4);
        for (int i = 0; i < 4; i++)
            if (i < n_ack) check($sformatf("cont_order%0d", i), order[i], i % 2);
        req0 = 0; req1 = 0;
        step();
        step();
        check("cont_idle", {gnt0, gnt1, mem_cs_n}, 3'b001);

        // Reset asserted on the first ACCESS cycle
        req0 = 1; addr0 = 16'h0600; mem_rdata = 32'hCAFEF00D;
        step();
        check("rst_mid_cs_before", mem_cs_n, 0);
        #1 RST = 1'b0;
        #1;
        check("rst_mid_cs", mem_cs_n, 1);
        check("rst_mid_gnt", {gnt0, gnt1}, 0);
        check("rst_mid_rdata", rdata, 0);
        step();
        check("rst_hold_ack", {ack0, ack1, err0, err1}, 0);
        step();
        check("rst_hold_cs", mem_cs_n, 1);
        RST = 1'b1;
        step();
        check("post_rst_cs", mem_cs_n, 0);
        check("post_rst_gnt", {gnt0, gnt1}, 2'b10);
        check("post_rst_addr", mem_addr, 10'h100);
        step();
        check("post_rst_noack", ack0, 0);
        step();
        check("post_rst_ack", {ack0, ack1, err0, err1}, 4'b1000);
        check("post_rst_rdata", rdata, 32'hCAFEF00D);
        req0 = 0;
        step();
        check("post_rst_idle", {gnt0, ack0}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
